// File: rtl/ccu_pkg.sv
// Shared CCU scheduler definitions: command width, idle command, long-flag bit
// and the issue FSM state type.
package ccu_pkg;
   localparam int CMD_W = 8;
   localparam logic [CMD_W-1:0] NOP_CMD = '0;
   localparam int LONG_BIT = 7;

   typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_e;
endpackage

// File: rtl/ccu_cmd_sched_if.sv
// Host-side command handshake into the CCU command scheduler.
interface ccu_cmd_sched_if #(parameter int CMD_W = 8);
   logic [CMD_W-1:0] cmd_in;
   logic             cmd_in_valid;
   logic             cmd_in_ready;

   modport master (output cmd_in, output cmd_in_valid, input cmd_in_ready);
   modport slave  (input cmd_in, input cmd_in_valid, output cmd_in_ready);
endinterface

// File: rtl/ccu_cmd_fifo.sv
// Small synchronous command FIFO with occupancy count and synchronous flush.
module ccu_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int CMD_W = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [CMD_W-1:0]       wdata,
   output logic [CMD_W-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);
   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][CMD_W-1:0] mem;
   logic [AW-1:0]               wr_ptr, rd_ptr;
   logic                        push_ok, pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/ccu_cmd_sched.sv
// CCU command scheduler: queues host commands and drives them onto the CCU
// cmd port one at a time, holding long commands for LONG_HOLD cycles.
module ccu_cmd_sched #(
   parameter int               DEPTH     = 4,
   parameter int               CMD_W     = ccu_pkg::CMD_W,
   parameter int               LONG_HOLD = 4,
   parameter logic [CMD_W-1:0] NOP_CMD   = ccu_pkg::NOP_CMD
) (
   input  logic                   clk,
   input  logic                   rst_n,
   ccu_cmd_sched_if.slave         host,
   input  logic                   stall,
   input  logic                   flush,
   output logic [CMD_W-1:0]       ccu_cmd,
   output logic                   ccu_issue,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count
);
   import ccu_pkg::*;

   localparam int HW = $clog2(LONG_HOLD);

   state_e           state;
   logic [HW-1:0]    hold_cnt;
   logic [CMD_W-1:0] head;
   logic             empty, full, push, pop, can_issue;
   logic [HW-1:0]    head_hold;

   assign host.cmd_in_ready = !full && !flush;
   assign push = host.cmd_in_valid && host.cmd_in_ready;

   // The next command may go out from IDLE, or back-to-back on the last hold cycle.
   assign can_issue = (state == IDLE) || (hold_cnt == '0);
   assign pop       = !flush && !stall && !empty && can_issue;
   assign head_hold = head[LONG_BIT] ? HW'(LONG_HOLD-1) : '0;
   assign busy      = (state == EXEC) || !empty;

   ccu_cmd_fifo #(.DEPTH(DEPTH), .CMD_W(CMD_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (host.cmd_in),
      .rdata (head),
      .count (fifo_count),
      .empty (empty),
      .full  (full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         hold_cnt  <= '0;
         ccu_cmd   <= NOP_CMD;
         ccu_issue <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         hold_cnt  <= '0;
         ccu_cmd   <= NOP_CMD;
         ccu_issue <= 1'b0;
      end else begin
         ccu_issue <= pop;
         if (pop) begin
            state    <= EXEC;
            ccu_cmd  <= head;
            hold_cnt <= head_hold;
         end else if (!stall && state == EXEC) begin
            if (hold_cnt != '0) begin
               hold_cnt <= hold_cnt - 1'b1;
            end else begin
               state   <= IDLE;
               ccu_cmd <= NOP_CMD;
            end
         end
      end
   end
endmodule
